// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Mealy serial-pattern detector.
// The pattern is reloadable at run time, and overlapping or non-overlapping
// detection is chosen each cycle. out is a combinational same-cycle strobe.
// Optional feature macro: SEQDET_COUNT_EN adds a saturating match counter
// on the match_count port.
module seq_detector_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             out
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_count
`endif
);

  localparam int                FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat, pat_nxt;
  logic [PAT_W-2:0]  hist, hist_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [PAT_W-1:0]  window;
  logic              accept;
  logic              armed;
  logic              match;

  // The candidate window is the held history plus the bit on the line now.
  // A pattern load in the same cycle discards the bit.
  assign window = {hist, in};
  assign accept = in_valid & ~pat_load;
  assign armed  = (fill == FULL);
  assign match  = accept & armed & (window == pat);

  // State register: pattern, history and fill level (fill is the FSM state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
    end else begin
      pat  <= pat_nxt;
      hist <= hist_nxt;
      fill <= fill_nxt;
    end
  end

  // Next state: a load restarts filling; a non-overlap match consumes the window.
  always_comb begin
    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    if (pat_load) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (in_valid) begin
      if (match && !overlap_en) begin
        hist_nxt = '0;
        fill_nxt = '0;
      end else begin
        hist_nxt = window[PAT_W-2:0];
        if (!armed) fill_nxt = fill + FILL_W'(1);
      end
    end
  end

  // Output: Mealy strobe, asserted in the cycle of the final pattern bit.
  always_comb begin
    out = match;
  end

`ifdef SEQDET_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Match counter: saturates at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_count <= '0;
    else if (out) match_count <= sat_inc(match_count);
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: the driver pushes the hand-computed
// expected out / match_count for each cycle, the monitor pops and compares.
module tb_seq_detector_param;

  localparam int D3 = 0;  // PAT_W=3, default pattern 101, CNT_W=8
  localparam int D4 = 1;  // PAT_W=4, reset pattern 0110
  localparam int DC = 2;  // PAT_W=3, CNT_W=2

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat_in3 = 3'b101;
  logic [3:0] pat_in4 = 4'b1101;
  logic       out3, out4, outc;
`ifdef SEQDET_COUNT_EN
  logic [7:0] cnt3, cnt4;
  logic [1:0] cntc;
`endif

  always #5 clk = ~clk;

  seq_detector_param u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in3), .out(out3)
`ifdef SEQDET_COUNT_EN
    , .match_count(cnt3)
`endif
  );

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b0110)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in4), .out(out4)
`ifdef SEQDET_COUNT_EN
    , .match_count(cnt4)
`endif
  );

  seq_detector_param #(.CNT_W(2)) u_dc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in3), .out(outc)
`ifdef SEQDET_COUNT_EN
    , .match_count(cntc)
`endif
  );

  typedef struct {
    int    dut;
    bit    eo;
    int    ec;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   total  = 0;
  int   passed = 0;

  // Monitor: one expected entry per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic o;
    int   c;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        o = (e.dut == D3) ? out3 : (e.dut == D4) ? out4 : outc;
        total++;
        if (o === e.eo) passed++;
        else $display("FAIL %s out: got %0b expected %0b", e.nm, o, e.eo);
`ifdef SEQDET_COUNT_EN
        c = (e.dut == D3) ? int'(cnt3) : (e.dut == D4) ? int'(cnt4) : int'(cntc);
        total++;
        if (c == e.ec) passed++;
        else $display("FAIL %s count: got %0d expected %0d", e.nm, c, e.ec);
`else
        c = e.ec;
`endif
      end
    end
  end

  task automatic step(input int d, input bit v, input bit b, input bit ld,
                      input bit eo, input int ec, input string nm);
    exp_t e;
    in_valid = v;
    in_bit   = b;
    pat_load = ld;
    e.dut = d; e.eo = eo; e.ec = ec; e.nm = nm;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    pat_load = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;

    // Reset state, then 101 non-overlap on stream 1,0,1,0,1
    rst = 1'b1;
    overlap_en = 1'b0;
    step(D3, 1, 1, 0, 0, 0, "reset");
    rst = 1'b0;
    step(D3, 1, 1, 0, 0, 0, "t1_b0");
    step(D3, 1, 0, 0, 0, 0, "t1_b1");
    step(D3, 1, 1, 0, 1, 0, "t1_b2");
    step(D3, 1, 0, 0, 0, 1, "t1_b3");
    step(D3, 1, 1, 0, 0, 1, "t1_b4");
    step(D3, 0, 0, 0, 0, 1, "t1_idle");

    // Same stream, overlapping
    pulse_reset();
    overlap_en = 1'b1;
    step(D3, 1, 1, 0, 0, 0, "t2_b0");
    step(D3, 1, 0, 0, 0, 0, "t2_b1");
    step(D3, 1, 1, 0, 1, 0, "t2_b2");
    step(D3, 1, 0, 0, 0, 1, "t2_b3");
    step(D3, 1, 1, 0, 1, 1, "t2_b4");
    step(D3, 0, 0, 0, 0, 2, "t2_idle");

    // Non-overlap 1,0,1,1,0,1
    pulse_reset();
    overlap_en = 1'b0;
    step(D3, 1, 1, 0, 0, 0, "t3_b0");
    step(D3, 1, 0, 0, 0, 0, "t3_b1");
    step(D3, 1, 1, 0, 1, 0, "t3_b2");
    step(D3, 1, 1, 0, 0, 1, "t3_b3");
    step(D3, 1, 0, 0, 0, 1, "t3_b4");
    step(D3, 1, 1, 0, 1, 1, "t3_b5");
    step(D3, 0, 0, 0, 0, 2, "t3_idle");

    // PAT_W=4: partial 011 of reset pattern 0110, load 1101 on the bit that
    // would have completed it, then 1,1,0,1
    pulse_reset();
    step(D4, 1, 0, 0, 0, 0, "t4_p0");
    step(D4, 1, 1, 0, 0, 0, "t4_p1");
    step(D4, 1, 1, 0, 0, 0, "t4_p2");
    step(D4, 1, 0, 1, 0, 0, "t4_load");
    step(D4, 1, 1, 0, 0, 0, "t4_b0");
    step(D4, 1, 1, 0, 0, 0, "t4_b1");
    step(D4, 1, 0, 0, 0, 0, "t4_b2");
    step(D4, 1, 1, 0, 1, 0, "t4_b3");
    step(D4, 0, 0, 0, 0, 1, "t4_idle");
    step(D4, 0, 0, 1, 0, 1, "t4_load2");
    step(D4, 0, 0, 0, 0, 1, "t4_keep");

    // in_valid gaps: 1,_,0,_,1 with in=1 in the gaps
    pulse_reset();
    step(D3, 1, 1, 0, 0, 0, "t5_v0");
    step(D3, 0, 1, 0, 0, 0, "t5_gap0");
    step(D3, 1, 0, 0, 0, 0, "t5_v1");
    step(D3, 0, 1, 0, 0, 0, "t5_gap1");
    step(D3, 1, 1, 0, 1, 0, "t5_v2");
    step(D3, 0, 0, 0, 0, 1, "t5_idle");

    // CNT_W=2 saturation: six overlapping matches of 101
    pulse_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 13; i++) begin
      int ec;
      ec = (i >= 3) ? (i - 1) / 2 : 0;
      if (ec > 3) ec = 3;
      step(DC, 1, (i % 2) == 0, 0, (i >= 2) && ((i % 2) == 0), ec, $sformatf("t6_b%0d", i));
    end
    step(DC, 0, 0, 0, 0, 3, "t6_idle");

    // Reset mid-stream after 10: the completing 1 is lost, next 1 restarts
    pulse_reset();
    overlap_en = 1'b0;
    step(D3, 1, 1, 0, 0, 0, "t7_b0");
    step(D3, 1, 0, 0, 0, 0, "t7_b1");
    rst = 1'b1;
    step(D3, 1, 1, 0, 0, 0, "t7_rst");
    rst = 1'b0;
    step(D3, 1, 1, 0, 0, 0, "t7_a0");
    step(D3, 1, 0, 0, 0, 0, "t7_a1");
    step(D3, 1, 1, 0, 1, 0, "t7_a2");
    step(D3, 0, 0, 0, 0, 1, "t7_idle");

    @(negedge clk);
    #1;
    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL drain: %0d entries left, expected 0", sbq.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
